// File: rtl/pll_lock_sequencer.sv
// Reset and lock sequencer for the system PLL: pulses the PLL reset, qualifies lock,
// then releases the downstream domain resets one at a time and watches for loss of lock.
module pll_lock_sequencer #(
  parameter int N_DOMAINS     = 5,
  parameter int RST_CYCLES    = 36,
  parameter int LOCK_TIMEOUT  = 36000,
  parameter int STABLE_CYCLES = 3600,
  parameter int STAGE_GAP     = 16,
  parameter int MAX_RETRY     = 3
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 locked,
  output logic                 pll_rst,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 ready,
  output logic                 fail,
  output logic [7:0]           lost_cnt,
  output logic [2:0]           fsm_state
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int LAST_STAGE = (N_DOMAINS - 1) * STAGE_GAP;
  localparam int CNT_MAX    = max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                   max2(STABLE_CYCLES, LAST_STAGE + 1));
  localparam int CW         = $clog2(CNT_MAX);
  localparam int RW         = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST    = CW'(LAST_STAGE - 1);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [RW-1:0]          retry, retry_d;
  logic [7:0]             lost_d;
  logic                   locked_m, locked_s;
  logic                   pll_rst_d, ready_d, fail_d;
  logic [N_DOMAINS-1:0]   domain_rst_d;

  assign fsm_state = state;

  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= locked;
      locked_s <= locked_m;
    end
  end

  // State register; outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= S_RESET;
      cnt        <= '0;
      retry      <= '0;
      lost_cnt   <= '0;
      pll_rst    <= 1'b1;
      domain_rst <= '1;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      retry      <= retry_d;
      lost_cnt   <= lost_d;
      pll_rst    <= pll_rst_d;
      domain_rst <= domain_rst_d;
      ready      <= ready_d;
      fail       <= fail_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    retry_d = retry;
    lost_d  = lost_cnt;
    unique case (state)
      S_RESET: begin
        if (cnt == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt == TO_LAST) begin
          retry_d = retry + RW'(1);
          state_d = (retry_d == RW'(MAX_RETRY)) ? S_FAIL : S_RESET;
        end
      end
      S_STABLE: begin
        if (!locked_s) state_d = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!locked_s) begin
          state_d = S_RESET;
        end else if (cnt == REL_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt;
        if (!locked_s) begin
          state_d = S_RESET;
          retry_d = '0;
          lost_d  = (lost_cnt == 8'hff) ? lost_cnt : lost_cnt + 8'd1;
        end
      end
      S_FAIL: begin
        cnt_d = cnt;
      end
      default: state_d = S_RESET;
    endcase
    if (state_d != state) cnt_d = '0;
    // restart overrides whatever the state decided this cycle, but never touches lost_cnt
    if (restart) begin
      state_d = S_RESET;
      cnt_d   = '0;
      retry_d = '0;
      lost_d  = lost_cnt;
    end
  end

  always_comb begin
    pll_rst_d    = (state_d == S_RESET) || (state_d == S_FAIL);
    ready_d      = (state_d == S_RUN);
    fail_d       = (state_d == S_FAIL);
    domain_rst_d = '1;
    if (state_d == S_RUN) begin
      domain_rst_d = '0;
    end else if (state_d == S_RELEASE) begin
      for (int i = 0; i < N_DOMAINS; i++) begin
        domain_rst_d[i] = (int'(cnt_d) < i * STAGE_GAP);
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

  localparam logic [2:0] ST_RESET   = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_STABLE  = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;
  localparam logic [2:0] ST_FAIL    = 3'd5;

  logic       refclk  = 1'b0;
  logic       rst     = 1'b1;
  logic       restart = 1'b0;
  logic       locked  = 1'b0;
  logic       pll_rst;
  logic [4:0] domain_rst;
  logic       ready;
  logic       fail;
  logic [7:0] lost_cnt;
  logic [2:0] fsm_state;

  int         n_pass  = 0;
  int         n_total = 0;
  int         n_fail  = 0;
  logic [7:0] exp_lost;

  pll_lock_sequencer #(
    .N_DOMAINS    (5),
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .STAGE_GAP    (2),
    .MAX_RETRY    (2)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .restart   (restart),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .domain_rst(domain_rst),
    .ready     (ready),
    .fail      (fail),
    .lost_cnt  (lost_cnt),
    .fsm_state (fsm_state)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic p, input logic [4:0] d,
                          input logic r, input logic f);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'(p));
    chk({tag, "_domain_rst"}, 32'(domain_rst), 32'(d));
    chk({tag, "_ready"}, 32'(ready), 32'(r));
    chk({tag, "_fail"}, 32'(fail), 32'(f));
  endtask

  // Expected domain_rst when the first RELEASE cycle is tick s and bits fall two ticks apart.
  function automatic logic [4:0] rel_dom(input int t, input int s);
    logic [4:0] all_ones;
    all_ones = 5'h1f;
    if (t < s) return all_ones;
    if (t >= s + 8) return 5'h00;
    return all_ones << ((t - s) / 2 + 1);
  endfunction

  // From RUN: drop locked, expect the reassert three ticks later, then a full re-sequence.
  task automatic lose_and_recover(input logic [7:0] exp_l);
    locked = 1'b0;
    tick();
    chk("loss_ready_hold", 32'(ready), 32'(1));
    tick();
    tick();
    chk_outs("loss", 1'b1, 5'h1f, 1'b0, 1'b0);
    chk("loss_lost_cnt", 32'(lost_cnt), 32'(exp_l));
    chk("loss_state", 32'(fsm_state), 32'(ST_RESET));
    locked = 1'b1;
    for (int k = 4; k <= 24; k++) begin
      tick();
      if (k == 6) chk("reseq_pll_high", 32'(pll_rst), 32'(1));
      if (k == 7) chk("reseq_pll_low", 32'(pll_rst), 32'(0));
      if (k == 23) chk("reseq_ready_early", 32'(ready), 32'(0));
    end
    chk("reseq_ready", 32'(ready), 32'(1));
    chk("reseq_domain_rst", 32'(domain_rst), 32'(0));
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    tick();
    chk_outs("reset", 1'b1, 5'h1f, 1'b0, 1'b0);
    chk("reset_lost_cnt", 32'(lost_cnt), 32'(0));
    chk("reset_state", 32'(fsm_state), 32'(ST_RESET));
    rst = 1'b0;

    // Nominal: locked rises two cycles after pll_rst falls
    for (int t = 1; t <= 26; t++) begin
      tick();
      chk("nom_pll_rst", 32'(pll_rst), 32'(t < 4));
      chk("nom_domain_rst", 32'(domain_rst), 32'(rel_dom(t, 17)));
      chk("nom_ready", 32'(ready), 32'(t >= 25));
      if (t == 4) chk("nom_state_wait", 32'(fsm_state), 32'(ST_WAIT));
      if (t == 9) chk("nom_state_stable", 32'(fsm_state), 32'(ST_STABLE));
      if (t == 17) chk("nom_state_release", 32'(fsm_state), 32'(ST_RELEASE));
      if (t == 25) chk("nom_state_run", 32'(fsm_state), 32'(ST_RUN));
      if (t == 6) locked = 1'b1;
    end
    chk("nom_lost_cnt", 32'(lost_cnt), 32'(0));

    // Glitch during STABLE: one low cycle restarts qualification without a new PLL reset
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk_outs("restart_run", 1'b1, 5'h1f, 1'b0, 1'b0);
    chk("restart_run_state", 32'(fsm_state), 32'(ST_RESET));
    for (int t = 1; t <= 30; t++) begin
      tick();
      chk("glitch_pll_rst", 32'(pll_rst), 32'(t < 4));
      chk("glitch_domain_rst", 32'(domain_rst), 32'(rel_dom(t, 21)));
      chk("glitch_ready", 32'(ready), 32'(t >= 29));
      if (t == 11) chk("glitch_state_stable", 32'(fsm_state), 32'(ST_STABLE));
      if (t == 12) chk("glitch_state_wait", 32'(fsm_state), 32'(ST_WAIT));
      if (t == 13) chk("glitch_state_restable", 32'(fsm_state), 32'(ST_STABLE));
      if (t == 9) locked = 1'b0;
      if (t == 10) locked = 1'b1;
    end

    // Loss of lock in RUN, three times
    lose_and_recover(8'd1);
    lose_and_recover(8'd2);
    lose_and_recover(8'd3);

    // restart during RELEASE after bit 1 has fallen
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (t == 13) chk("mid_rel_bit0", 32'(domain_rst), 32'(5'h1e));
    end
    chk("mid_rel_bit1", 32'(domain_rst), 32'(5'h1c));
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk_outs("mid_rel_restart", 1'b1, 5'h1f, 1'b0, 1'b0);
    chk("mid_rel_state", 32'(fsm_state), 32'(ST_RESET));
    chk("mid_rel_lost_kept", 32'(lost_cnt), 32'(3));
    for (int t = 1; t <= 21; t++) begin
      tick();
      if (t == 20) chk("mid_rel_ready_early", 32'(ready), 32'(0));
    end
    chk("mid_rel_ready", 32'(ready), 32'(1));
    chk("mid_rel_domain_rst", 32'(domain_rst), 32'(0));

    // rst mid-RUN clears everything including lost_cnt
    chk("pre_rst_lost_cnt", 32'(lost_cnt), 32'(3));
    rst = 1'b1;
    tick();
    chk_outs("rst_run", 1'b1, 5'h1f, 1'b0, 1'b0);
    chk("rst_run_lost_cnt", 32'(lost_cnt), 32'(0));
    chk("rst_run_state", 32'(fsm_state), 32'(ST_RESET));
    rst = 1'b0;
    for (int t = 1; t <= 21; t++) begin
      tick();
      if (t == 20) chk("rst_reseq_ready_early", 32'(ready), 32'(0));
    end
    chk("rst_reseq_ready", 32'(ready), 32'(1));

    // Lock timeouts exhaust the retry budget
    restart = 1'b1;
    locked = 1'b0;
    tick();
    restart = 1'b0;
    chk_outs("to_start", 1'b1, 5'h1f, 1'b0, 1'b0);
    for (int t = 1; t <= 58; t++) begin
      tick();
      chk("to_pll_rst", 32'(pll_rst), 32'((t < 4) || (t >= 24 && t < 28) || (t >= 48)));
      chk("to_fail", 32'(fail), 32'(t >= 48));
      chk("to_domain_rst", 32'(domain_rst), 32'(5'h1f));
      chk("to_ready", 32'(ready), 32'(0));
      if (t == 23) chk("to_state_wait", 32'(fsm_state), 32'(ST_WAIT));
      if (t == 24) chk("to_state_reset", 32'(fsm_state), 32'(ST_RESET));
      if (t == 48) chk("to_state_fail", 32'(fsm_state), 32'(ST_FAIL));
      if (t == 58) chk("to_state_fail_held", 32'(fsm_state), 32'(ST_FAIL));
    end
    restart = 1'b1;
    locked = 1'b1;
    tick();
    restart = 1'b0;
    chk_outs("fail_restart", 1'b1, 5'h1f, 1'b0, 1'b0);
    chk("fail_restart_state", 32'(fsm_state), 32'(ST_RESET));
    for (int t = 1; t <= 21; t++) begin
      tick();
      if (t == 20) chk("fail_reseq_ready_early", 32'(ready), 32'(0));
    end
    chk("fail_reseq_ready", 32'(ready), 32'(1));
    chk("fail_reseq_domain_rst", 32'(domain_rst), 32'(0));

    // lost_cnt saturation
    exp_lost = 8'd0;
    for (int i = 0; i < 260; i++) begin
      exp_lost = (exp_lost == 8'hff) ? 8'hff : exp_lost + 8'd1;
      lose_and_recover(exp_lost);
    end
    chk("sat_lost_cnt", 32'(lost_cnt), 32'(8'hff));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
